// File: rtl/alu_logic_seq_if.sv
// Valid/ready bus between the execute stage and the chunk-serial bitwise unit.
// The producer drives operands and op. The consumer takes result, zero and parity.
interface alu_logic_seq_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;

    // Execute-stage side: offers operands, accepts results.
    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, zero, parity
    );

    // Unit side.
    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, zero, parity
    );
endinterface

// File: rtl/alu_logic_seq.sv
// Multi-cycle bitwise unit. It applies one of eight bitwise ops to WIDTH-bit operands,
// CHUNK bits per cycle, behind a valid/ready handshake.
// Optional macro ALU_LOGIC_PARITY_EN enables the registered parity flag. Without it,
// parity is tied to 0.
module alu_logic_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_logic_seq_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // A partial last chunk cannot be expressed by the chunk-serial datapath.
    if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_chunk_check
        $error("alu_logic_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q;
    logic             load;
    logic             busy;
    logic             last;
    logic [CHUNK-1:0] a_slice, b_slice, chunk_res;

    function automatic logic [CHUNK-1:0] apply_op(input logic [2:0]       o,
                                                  input logic [CHUNK-1:0] a,
                                                  input logic [CHUNK-1:0] b);
        logic [CHUNK-1:0] r;
        unique case (o)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: r = a ^ b;
            3'b011: r = ~(a | b);
            3'b100: r = a & ~b;
            3'b101: r = a | ~b;
            3'b110: r = ~(a ^ b);
            3'b111: r = a;
        endcase
        return r;
    endfunction

    assign busy = (state_q == StBusy);
    assign last = (idx_q == LAST_IDX);

    // Select the operand slices addressed by the chunk index.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_slice = a_q[i*CHUNK +: CHUNK];
                b_slice = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_res = apply_op(op_q, a_slice, b_slice);

    // Merge the freshly computed chunk into the result. Other chunks keep their old bits.
    always_comb begin
        result_d = result_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                result_d[i*CHUNK +: CHUNK] = chunk_res;
            end
        end
    end

    // Control FSM: accept in IDLE, one chunk per BUSY cycle, hold in DONE until taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StBusy;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            StBusy: begin
                if (last) begin
                    state_d = StDone;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // State and chunk index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Operands are captured once at accept, so the producer may change them afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= 3'b000;
        end else if (load) begin
            a_q  <= bus.A;
            b_q  <= bus.B;
            op_q <= bus.op;
        end
    end

    // Result builds up chunk by chunk. Zero is taken from the complete word on the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (busy) begin
            result_q <= result_d;
            if (last) begin
                zero_q <= (result_d == '0);
            end
        end
    end

`ifdef ALU_LOGIC_PARITY_EN
    logic parity_q;

    // Parity is registered alongside zero from the complete result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (busy && last) begin
            parity_q <= ^result_d;
        end
    end

    assign bus.parity = parity_q;
`else
    assign bus.parity = 1'b0;
`endif

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_logic_seq.sv
// Directed bench for alu_logic_seq. One instance uses 32/8 and another uses 16/16.
module tb_alu_logic_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu_logic_seq_if #(.WIDTH(32)) bus ();
    alu_logic_seq_if #(.WIDTH(16)) bus16 ();

    alu_logic_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_logic_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic par_exp(input logic p);
`ifdef ALU_LOGIC_PARITY_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    // Called #1 after an edge while the unit is idle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] o, input logic [31:0] exp_r, input logic exp_z,
                          input logic exp_p);
        int cnt;
        chk({tag, ".in_ready"}, bus.in_ready, 1'b1);
        bus.A = a;
        bus.B = b;
        bus.op = o;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        bus.op = ~o;
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, ".latency"}, cnt, 4);
        chk({tag, ".result"}, bus.result, exp_r);
        chk({tag, ".zero"}, bus.zero, exp_z);
        chk({tag, ".parity"}, bus.parity, par_exp(exp_p));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, bus.out_valid, 1'b0);
        chk({tag, ".in_ready_back"}, bus.in_ready, 1'b1);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] o, input logic [15:0] exp_r, input logic exp_p);
        bus16.A = a;
        bus16.B = b;
        bus16.op = o;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        chk({tag, ".busy"}, bus16.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, ".latency1"}, bus16.out_valid, 1'b1);
        chk({tag, ".result"}, bus16.result, exp_r);
        chk({tag, ".parity"}, bus16.parity, par_exp(exp_p));
        bus16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus16.out_ready = 1'b0;
        chk({tag, ".in_ready_back"}, bus16.in_ready, 1'b1);
    endtask

    initial begin
        int cnt;
        logic [31:0] ops_exp [8];
        ops_exp[0] = 32'hF000A500;
        ops_exp[1] = 32'hFFF0FFA5;
        ops_exp[2] = 32'h0FF05AA5;
        ops_exp[3] = 32'h000F005A;
        ops_exp[4] = 32'h00F000A5;
        ops_exp[5] = 32'hF0FFA5FF;
        ops_exp[6] = 32'hF00FA55A;
        ops_exp[7] = 32'hF0F0A5A5;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.op = 3'b000;
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b0;
        bus16.A = '0;
        bus16.B = '0;
        bus16.op = 3'b000;

        // Reset state
        #1;
        chk("rst.result", bus.result, 32'h0);
        chk("rst.zero", bus.zero, 1'b0);
        chk("rst.parity", bus.parity, 1'b0);
        chk("rst.in_ready", bus.in_ready, 1'b1);
        chk("rst.out_valid", bus.out_valid, 1'b0);
        #12 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset asserted after two BUSY cycles aborts the operation
        bus.A = 32'hFFFFFFFF;
        bus.B = 32'h0F0F0F0F;
        bus.op = 3'b000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.result", bus.result, 32'h0);
        chk("midrst.out_valid", bus.out_valid, 1'b0);
        chk("midrst.in_ready", bus.in_ready, 1'b1);
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst.no_late_valid", bus.out_valid, 1'b0);

        // Basic AND with latency
        run_op("and", 32'h12345678, 32'h0F0F0F0F, 3'b000, 32'h02040608, 1'b0, 1'b1);

        // All eight ops
        for (int o = 0; o < 8; o++) begin
            run_op($sformatf("op%0d", o), 32'hF0F0A5A5, 32'hFF00FF00, 3'(o), ops_exp[o],
                   1'b0, 1'b0);
        end

        // Zero and parity flags
        run_op("xor_zero", 32'hDEADBEEF, 32'hDEADBEEF, 3'b010, 32'h0, 1'b1, 1'b0);
        run_op("pass_par", 32'h00000001, 32'h12345678, 3'b111, 32'h00000001, 1'b0, 1'b1);

        // Backpressure in DONE
        bus.A = 32'h0;
        bus.B = 32'h0;
        bus.op = 3'b110;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("bp.latency", cnt, 4);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.A = $urandom;
            bus.B = $urandom;
            bus.op = 3'b000;
            @(posedge clk);
            #1;
            chk("bp.result", bus.result, 32'hFFFFFFFF);
            chk("bp.in_ready", bus.in_ready, 1'b0);
            chk("bp.out_valid", bus.out_valid, 1'b1);
        end
        chk("bp.parity", bus.parity, 1'b0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp.in_ready_after", bus.in_ready, 1'b1);
        chk("bp.out_valid_after", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("bp.no_second_accept", bus.in_ready, 1'b1);

        // Single-chunk configuration
        run16("w16_nor", 16'h00FF, 16'h0F00, 3'b011, 16'hF000, 1'b0);
        run16("w16_andn", 16'hABCD, 16'h00FF, 3'b100, 16'hAB00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_logic_seq.md
Name: alu_logic_seq

Overview:
- Parametrised, multi-cycle successor to the ALU's single-function bitwise unit.
- Performs one of eight bitwise operations on WIDTH-bit operands, CHUNK bits per clock, using a chunk-serial datapath.
- Produces a registered result, a zero flag and an optional parity flag.
- Sits in the MIPS ALU behind a valid/ready handshake, so the execute stage can stall on it.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits processed per BUSY cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails via $error.
- NCHUNK (localparam), WIDTH/CHUNK: number of BUSY cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand/op offer.
- in_ready  output  1  unit can accept; high only in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  operation select.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0, registered with result.
- parity  output  1  XOR-reduction of result; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, chunk index=0, result=0, zero=0, parity=0, out_valid=0, in_ready=1. Operand registers cleared to 0.
- Reset asserted mid-operation: the operation is aborted and discarded, with no partial result visible. After deassertion the unit is in IDLE.
- op encoding:
  - 000 A&B, 001 A|B, 010 A^B, 011 ~(A|B)
  - 100 A&~B, 101 A|~B, 110 ~(A^B), 111 A (pass-through)
- IDLE:
  - in_ready=1.
  - On clk edge with in_valid=1: latch A, B, op; index=0; go to BUSY.
  - A, B, op may change freely after the accept edge.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge writes result[index*CHUNK +: CHUNK] = op applied to the latched slices, then index increments.
  - The edge writing index NCHUNK-1 also registers zero and parity from the complete result and goes to DONE.
  - Result bits for chunks not yet written hold their previous values. Downstream must not sample while out_valid=0.
- DONE:
  - out_valid=1; result, zero and parity are stable.
  - On edge with out_ready=1: go to IDLE, out_valid drops next cycle.
  - out_ready=0 holds DONE indefinitely.
  - in_valid is ignored, because in_ready=0.
- Latency: accept at edge k gives out_valid high after edge k+NCHUNK. With WIDTH=32, CHUNK=8, that is 4 cycles.
- Throughput: at best one op per NCHUNK+2 cycles (accept, NCHUNK BUSY, handoff, IDLE). There is no accept during DONE.
- CHUNK==WIDTH: a single BUSY cycle; latency 1.
- The index counter is $clog2(NCHUNK) bits wide, minimum 1. It never wraps in use, because the BUSY exit is decided at NCHUNK-1.
- Handshake: accept = in_valid & in_ready, delivery = out_valid & out_ready, both evaluated at the rising edge. No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: ALU_LOGIC_PARITY_EN.
- Defined: parity = ^result, registered on the final BUSY edge alongside zero, and cleared by reset.
- Undefined: the parity port remains but is tied to 0. No parity logic is synthesised and the port list is unchanged.

Test Plan:
- Reset check: assert rst mid-BUSY (op 000, A=FFFFFFFF, B=0F0F0F0F, after 2 BUSY cycles) -> result=0, out_valid=0, in_ready=1 immediately. After release, the next op completes normally.
- Basic AND, latency: WIDTH=32/CHUNK=8, A=12345678, B=0F0F0F0F, op=000 -> out_valid exactly 4 edges after accept, result=02040608, zero=0.
- All ops: A=F0F0A5A5, B=FF00FF00, ops 000..111 -> results in order:
  - F000A500, FFF0FFA5, 0FF05AA5, 000F005A
  - 00F000A5, F0FFA5FF, F00FA55A, F0F0A5A5
- Zero and parity: op 010, A=B=DEADBEEF -> result=0, zero=1, parity=0. Op 111, A=00000001 -> zero=0, parity=1 with ALU_LOGIC_PARITY_EN defined, and 0 without it.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and changing A/B -> result stable, in_ready=0, no second accept. Raising out_ready completes the handoff and in_ready=1 the next cycle.
- Parameter sweep: WIDTH=16/CHUNK=16 (latency 1) and WIDTH=64/CHUNK=4 (latency 16) with random ops compared against a reference model over 1000 ops -> zero mismatches. WIDTH=30/CHUNK=8 must fail elaboration.
